ysyx_axi_rd_arb: RTL and testbench
==================================

// Module: ysyx_axi_rd_arb
// PURPOSE
// - Arbitrates IFU fetch and LSU load read requests onto the single AXI4 read channel (AR/R) of io_master.
// - Allows one outstanding transaction at a time, and supports INCR bursts such as SDRAM fetch bursts.
// - Routes R beats back to the granted requester and flags protocol errors per requester.
// - Sits between the IFU/LSU and the SoC AXI4 master port, replacing the ad-hoc load state machine inside the bus.
// PARAMETERS
// - XLEN     32   address/data width.
// - IFU_ID   0    ARID driven for IFU transactions.
// - LSU_ID   1    ARID driven for LSU transactions.
// - TIMEOUT  256  idle R-channel cycles before the watchdog fires; only used with YSYX_RD_ARB_TIMEOUT_EN.
// PORTS
// - clock               in   1     single clock.
// - reset               in   1     asynchronous, active-low reset.
// - ifu_arvalid         in   1     IFU request; held until out_ifu_arready.
// - ifu_araddr          in   XLEN  IFU address.
// - ifu_arlen           in   8     IFU burst length-1.
// - ifu_lock            in   1     1 = LSU may not be granted.
// - out_ifu_arready     out  1     IFU request accepted, one-cycle pulse.
// - out_ifu_rdata       out  XLEN  IFU read data; 0 unless out_ifu_rvalid.
// - out_ifu_rvalid      out  1     IFU data beat.
// - out_ifu_rlast       out  1     last IFU beat.
// - out_ifu_rerr        out  1     beat carries an error (rresp!=0, bad rid, bad length, timeout).
// - lsu_arvalid/lsu_araddr/lsu_arsize(3)             LSU request; single beat only (ARLEN=0).
// - out_lsu_arready/out_lsu_rdata/out_lsu_rvalid/out_lsu_rerr    as for IFU.
// - io_master_arvalid/araddr/arid(4)/arlen(8)/arsize(3)/arburst(2)   out; arready is in.
// - io_master_rvalid/rdata/rid(4)/rresp(2)/rlast     in; io_master_rready is out.
// BEHAVIOUR
// - States: IDLE, ADDR, DATA, DRAIN.
// - Reset (asynchronous, active-low): state=IDLE, last_grant=LSU so the IFU wins the first tie, and all outputs and latched fields are 0.
// - IDLE, grant is combinational:
//   - LSU is eligible iff lsu_arvalid && !ifu_lock.
//   - Both IFU and LSU eligible: grant the one that is not last_grant (round-robin).
//   - Only one eligible: grant it.
//   - Granted requester: out_*_arready=1 in the same cycle; address, arlen, arsize and id are latched; state moves to ADDR next cycle.
// - ADDR:
//   - io_master_arvalid=1 from the latched registers; fields are stable until arready.
//   - IFU requests use arsize=3'b010 and arburst=2'b01 when arlen!=0, otherwise 2'b00.
//   - LSU requests use arlen=0.
//   - On arvalid&&arready: go to DATA and clear beat_cnt.
// - DATA:
//   - io_master_rready=1. Read data passes through combinationally to the granted requester in the same cycle as io_master_rvalid; the other requester's outputs stay 0.
//   - beat_cnt increments per beat.
//   - rerr = (rresp!=0) | (rid!=latched id) | (rlast && beat_cnt!=arlen) | (!rlast && beat_cnt==arlen).
//   - On a beat with rlast: go to IDLE and set last_grant=granted.
//   - Excess beats (beat_cnt==arlen && !rlast): go to DRAIN.
// - DRAIN:
//   - rready=1; beats are discarded and no requester sees rvalid.
//   - On rlast: go to IDLE.
// - io_master_rready=0 in IDLE and ADDR.
// - Minimum request-to-first-data latency: arready at cycle N, AR handshake at N+1, first R beat at N+2 or later.
// - Back-to-back: a new grant is possible in the cycle after the last beat. An IFU request arriving during an LSU transaction waits and wins next under round-robin.
// - ifu_lock changing while LSU is mid-transaction has no effect until the next IDLE.
// - Requester dropping arvalid after acceptance: the transaction still completes and data is still returned.
// - Reset asserted mid-transaction: returns to IDLE immediately. Any in-flight slave response after reset release is not tracked (SoC reset is shared).
// CONFIGURATION
// - YSYX_RD_ARB_TIMEOUT_EN defined:
//   - A watchdog counter runs in ADDR and DATA. It clears on arready or on any R beat.
//   - When it reaches TIMEOUT-1, the granted requester gets one beat with rvalid=1, rlast=1, rerr=1 and rdata=0.
//   - After that beat: go to IDLE if still in ADDR (arvalid drops), otherwise go to DRAIN.
// - YSYX_RD_ARB_TIMEOUT_EN undefined: no counter; the arbiter waits indefinitely.
// TESTING
// - IFU araddr=0xa0000000, arlen=1, with the slave returning 2 beats -> arburst=01, arid=0, 2 IFU beats with rlast on the 2nd, rerr=0.
// - IFU and LSU valid in the same IDLE cycle after reset -> IFU granted first, then LSU. Repeat the tie -> IFU again (last_grant=LSU).
// - ifu_lock=1 with LSU valid and IFU idle -> no LSU grant. Drop lock -> LSU granted in that cycle, arsize=lsu_arsize.
// - LSU read where the slave returns rid=0 and rresp=2'b10 -> out_lsu_rvalid=1, out_lsu_rerr=1; IFU outputs stay 0.
// - IFU arlen=0 with the slave returning 2 beats -> first beat rerr=1, second beat discarded in DRAIN, then IDLE.
// - Timeout enabled, TIMEOUT=8, slave never asserts rvalid -> rerr beat 8 cycles after the AR handshake, then DRAIN. Reset mid-DATA -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ysyx_axi_rd_arb.sv
// ysyx_axi_rd_arb: arbitrates IFU fetch and LSU load reads onto one AXI4 AR/R
// channel with a single outstanding transaction and INCR burst support.
//
// Ports
//   clock, reset          clock and asynchronous active-low reset
//   ifu_*                 IFU request (addr, burst length-1, lock) and R return
//   lsu_*                 LSU request (addr, size; single beat) and R return
//   io_master_*           AXI4 read address / read data channels
//
// Optional feature: define YSYX_RD_ARB_TIMEOUT_EN to enable an R-channel
// watchdog that answers a stalled transaction with an error beat after
// TIMEOUT idle cycles.
module ysyx_axi_rd_arb #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned IFU_ID  = 0,
  parameter int unsigned LSU_ID  = 1,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ifu_arvalid,
  input  logic [XLEN-1:0] ifu_araddr,
  input  logic [7:0]      ifu_arlen,
  input  logic            ifu_lock,
  output logic            out_ifu_arready,
  output logic [XLEN-1:0] out_ifu_rdata,
  output logic            out_ifu_rvalid,
  output logic            out_ifu_rlast,
  output logic            out_ifu_rerr,
  input  logic            lsu_arvalid,
  input  logic [XLEN-1:0] lsu_araddr,
  input  logic [2:0]      lsu_arsize,
  output logic            out_lsu_arready,
  output logic [XLEN-1:0] out_lsu_rdata,
  output logic            out_lsu_rvalid,
  output logic            out_lsu_rerr,
  output logic            io_master_arvalid,
  input  logic            io_master_arready,
  output logic [XLEN-1:0] io_master_araddr,
  output logic [3:0]      io_master_arid,
  output logic [7:0]      io_master_arlen,
  output logic [2:0]      io_master_arsize,
  output logic [1:0]      io_master_arburst,
  input  logic            io_master_rvalid,
  output logic            io_master_rready,
  input  logic [XLEN-1:0] io_master_rdata,
  input  logic [3:0]      io_master_rid,
  input  logic [1:0]      io_master_rresp,
  input  logic            io_master_rlast
);

  localparam int unsigned ID_W  = 4;
  localparam int unsigned LEN_W = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ADDR  = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

  // The watchdog compare needs TIMEOUT-1 to be a meaningful count.
  if (TIMEOUT < 2) begin : g_timeout_chk
    $error("ysyx_axi_rd_arb: TIMEOUT must be at least 2");
  end

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_q, grant_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [2:0]       size_q, size_d;
  logic [1:0]       burst_q, burst_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;

  logic             ifu_elig, lsu_elig, pick_lsu;
  logic             beat_v, beat_last, beat_err;
  logic [XLEN-1:0]  beat_data;
  logic             tmo_c;

`ifdef YSYX_RD_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT) + 1;

  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_run, wd_clr;

  // Watchdog: counts stalled ADDR/DATA cycles, cleared by any channel progress.
  always_comb begin
    wd_run = (state_q == ADDR) || (state_q == DATA);
    wd_clr = !wd_run
           || ((state_q == ADDR) && io_master_arready)
           || ((state_q == DATA) && io_master_rvalid);
    tmo_c  = !wd_clr && (wd_q == WD_W'(TIMEOUT - 1));
    wd_d   = (wd_clr || tmo_c) ? '0 : wd_q + WD_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  assign tmo_c = 1'b0;
`endif

  // Next-state, grant and beat routing.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    id_d         = id_q;
    beat_cnt_d   = beat_cnt_q;

    out_ifu_arready   = 1'b0;
    out_lsu_arready   = 1'b0;
    io_master_arvalid = 1'b0;
    io_master_rready  = 1'b0;
    beat_v            = 1'b0;
    beat_last         = 1'b0;
    beat_err          = 1'b0;
    beat_data         = '0;

    ifu_elig = ifu_arvalid;
    lsu_elig = lsu_arvalid && !ifu_lock;
    // On a tie the requester that was not served last wins.
    pick_lsu = lsu_elig && (!ifu_elig || (last_grant_q == GNT_IFU));

    case (state_q)
      IDLE: begin
        if (ifu_elig || lsu_elig) begin
          state_d = ADDR;
          grant_d = pick_lsu;
          if (pick_lsu) begin
            out_lsu_arready = 1'b1;
            addr_d  = lsu_araddr;
            len_d   = '0;
            size_d  = lsu_arsize;
            burst_d = 2'b00;
            id_d    = ID_W'(LSU_ID);
          end else begin
            out_ifu_arready = 1'b1;
            addr_d  = ifu_araddr;
            len_d   = ifu_arlen;
            size_d  = 3'b010;
            burst_d = (ifu_arlen != '0) ? 2'b01 : 2'b00;
            id_d    = ID_W'(IFU_ID);
          end
        end
      end
      ADDR: begin
        io_master_arvalid = 1'b1;
        if (io_master_arready) begin
          state_d    = DATA;
          beat_cnt_d = '0;
        end else if (tmo_c) begin
          // Address never accepted: answer with an error beat and withdraw.
          beat_v       = 1'b1;
          beat_last    = 1'b1;
          beat_err     = 1'b1;
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end
      DATA: begin
        io_master_rready = 1'b1;
        if (io_master_rvalid) begin
          beat_v     = 1'b1;
          beat_data  = io_master_rdata;
          beat_last  = io_master_rlast;
          beat_err   = (io_master_rresp != 2'b00)
                     || (io_master_rid != id_q)
                     || (io_master_rlast && (beat_cnt_q != len_q))
                     || (!io_master_rlast && (beat_cnt_q == len_q));
          beat_cnt_d = beat_cnt_q + LEN_W'(1);
          if (io_master_rlast) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
          end else if (beat_cnt_q == len_q) begin
            // Slave is sending more beats than requested; swallow the rest.
            state_d      = DRAIN;
            last_grant_d = grant_q;
          end
        end else if (tmo_c) begin
          // Slave may still answer later, so discard whatever arrives.
          beat_v       = 1'b1;
          beat_last    = 1'b1;
          beat_err     = 1'b1;
          state_d      = DRAIN;
          last_grant_d = grant_q;
        end
      end
      DRAIN: begin
        io_master_rready = 1'b1;
        if (io_master_rvalid && io_master_rlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    out_ifu_rvalid = beat_v && (grant_q == GNT_IFU);
    out_ifu_rdata  = out_ifu_rvalid ? beat_data : '0;
    out_ifu_rlast  = out_ifu_rvalid && beat_last;
    out_ifu_rerr   = out_ifu_rvalid && beat_err;
    out_lsu_rvalid = beat_v && (grant_q == GNT_LSU);
    out_lsu_rdata  = out_lsu_rvalid ? beat_data : '0;
    out_lsu_rerr   = out_lsu_rvalid && beat_err;
  end

  // State and latched request fields.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_LSU;
      grant_q      <= GNT_IFU;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      id_q         <= '0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      id_q         <= id_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign io_master_araddr  = addr_q;
  assign io_master_arid    = id_q;
  assign io_master_arlen   = len_q;
  assign io_master_arsize  = size_q;
  assign io_master_arburst = burst_q;

endmodule

// File: tb/tb_ysyx_axi_rd_arb.sv
// Directed bench for ysyx_axi_rd_arb: single-beat transactions from a vector
// table plus hand-written sequences for arbitration, bursts and corner cases.
module tb_ysyx_axi_rd_arb;

  logic        clock;
  logic        reset;
  logic        ifu_arvalid;
  logic [31:0] ifu_araddr;
  logic [7:0]  ifu_arlen;
  logic        ifu_lock;
  logic        out_ifu_arready;
  logic [31:0] out_ifu_rdata;
  logic        out_ifu_rvalid;
  logic        out_ifu_rlast;
  logic        out_ifu_rerr;
  logic        lsu_arvalid;
  logic [31:0] lsu_araddr;
  logic [2:0]  lsu_arsize;
  logic        out_lsu_arready;
  logic [31:0] out_lsu_rdata;
  logic        out_lsu_rvalid;
  logic        out_lsu_rerr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_araddr;
  logic [3:0]  m_arid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] m_rdata;
  logic [3:0]  m_rid;
  logic [1:0]  m_rresp;
  logic        m_rlast;

  int checks = 0;
  int errors = 0;

  ysyx_axi_rd_arb #(.XLEN(32), .IFU_ID(0), .LSU_ID(1), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arlen(ifu_arlen),
    .ifu_lock(ifu_lock), .out_ifu_arready(out_ifu_arready),
    .out_ifu_rdata(out_ifu_rdata), .out_ifu_rvalid(out_ifu_rvalid),
    .out_ifu_rlast(out_ifu_rlast), .out_ifu_rerr(out_ifu_rerr),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize),
    .out_lsu_arready(out_lsu_arready), .out_lsu_rdata(out_lsu_rdata),
    .out_lsu_rvalid(out_lsu_rvalid), .out_lsu_rerr(out_lsu_rerr),
    .io_master_arvalid(m_arvalid), .io_master_arready(m_arready),
    .io_master_araddr(m_araddr), .io_master_arid(m_arid),
    .io_master_arlen(m_arlen), .io_master_arsize(m_arsize),
    .io_master_arburst(m_arburst), .io_master_rvalid(m_rvalid),
    .io_master_rready(m_rready), .io_master_rdata(m_rdata),
    .io_master_rid(m_rid), .io_master_rresp(m_rresp), .io_master_rlast(m_rlast)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        lsu;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic [1:0]  rresp;
    logic        exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // IDLE-cycle request: drive valids/lock and check the same-cycle grant.
  task automatic step_req(input logic iv, input logic lv, input logic lk,
                          input logic e_ir, input logic e_lr, input string nm);
    @(negedge clock);
    ifu_arvalid = iv; lsu_arvalid = lv; ifu_lock = lk;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    chk({nm, "_ifu_arready"}, 32'(out_ifu_arready), 32'(e_ir));
    chk({nm, "_lsu_arready"}, 32'(out_lsu_arready), 32'(e_lr));
  endtask

  // ADDR cycle: slave accepts; check the presented AR fields.
  task automatic step_ar(input logic iv, input logic lv, input logic [31:0] e_addr,
                         input logic [3:0] e_id, input logic [7:0] e_len,
                         input logic [2:0] e_size, input logic [1:0] e_burst,
                         input string nm);
    @(negedge clock);
    ifu_arvalid = iv; lsu_arvalid = lv;
    m_arready = 1'b1; m_rvalid = 1'b0;
    #1;
    chk({nm, "_arvalid"}, 32'(m_arvalid), 32'd1);
    chk({nm, "_araddr"}, m_araddr, e_addr);
    chk({nm, "_arid"}, 32'(m_arid), 32'(e_id));
    chk({nm, "_arlen"}, 32'(m_arlen), 32'(e_len));
    chk({nm, "_arsize"}, 32'(m_arsize), 32'(e_size));
    chk({nm, "_arburst"}, 32'(m_arburst), 32'(e_burst));
    chk({nm, "_ar_rready"}, 32'(m_rready), 32'd0);
  endtask

  // One R beat from the slave; check routing to the expected requester.
  task automatic step_r(input logic [31:0] d, input logic [3:0] id, input logic [1:0] resp,
                        input logic last, input logic to_lsu, input logic e_v,
                        input logic ck_last, input logic e_err, input string nm);
    @(negedge clock);
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = d; m_rid = id; m_rresp = resp; m_rlast = last;
    #1;
    chk({nm, "_rready"}, 32'(m_rready), 32'd1);
    if (to_lsu) begin
      chk({nm, "_lsu_rvalid"}, 32'(out_lsu_rvalid), 32'(e_v));
      chk({nm, "_lsu_rdata"}, out_lsu_rdata, e_v ? d : 32'd0);
      chk({nm, "_lsu_rerr"}, 32'(out_lsu_rerr), 32'(e_err));
      chk({nm, "_ifu_rvalid"}, 32'(out_ifu_rvalid), 32'd0);
      chk({nm, "_ifu_rdata"}, out_ifu_rdata, 32'd0);
    end else begin
      chk({nm, "_ifu_rvalid"}, 32'(out_ifu_rvalid), 32'(e_v));
      chk({nm, "_ifu_rdata"}, out_ifu_rdata, e_v ? d : 32'd0);
      chk({nm, "_ifu_rerr"}, 32'(out_ifu_rerr), 32'(e_err));
      if (ck_last) chk({nm, "_ifu_rlast"}, 32'(out_ifu_rlast), 32'(e_v & last));
      chk({nm, "_lsu_rvalid"}, 32'(out_lsu_rvalid), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b0;
    ifu_arvalid = 1'b0; ifu_araddr = '0; ifu_arlen = '0; ifu_lock = 1'b0;
    lsu_arvalid = 1'b0; lsu_araddr = '0; lsu_arsize = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rid = '0; m_rresp = '0; m_rlast = 1'b0;

    vecs[0] = '{1'b1, 32'h8000_0010, 3'b010, 32'hdead_beef, 4'd1, 2'b00, 1'b0};
    vecs[1] = '{1'b1, 32'h8000_0021, 3'b000, 32'h0000_00aa, 4'd0, 2'b10, 1'b1};
    vecs[2] = '{1'b0, 32'h3000_0004, 3'b000, 32'h1234_5678, 4'd0, 2'b00, 1'b0};
    vecs[3] = '{1'b0, 32'h3000_0008, 3'b000, 32'hcafe_babe, 4'd1, 2'b00, 1'b1};
    vecs[4] = '{1'b1, 32'h8000_0032, 3'b001, 32'h5555_aaaa, 4'd1, 2'b11, 1'b1};
    vecs[5] = '{1'b0, 32'h3000_000c, 3'b000, 32'h0f0f_0f0f, 4'd0, 2'b01, 1'b1};

    // Reset state.
    repeat (2) @(negedge clock);
    #1;
    chk("rst_arvalid", 32'(m_arvalid), 32'd0);
    chk("rst_rready", 32'(m_rready), 32'd0);
    chk("rst_araddr", m_araddr, 32'd0);
    chk("rst_arlen", 32'(m_arlen), 32'd0);
    chk("rst_arid", 32'(m_arid), 32'd0);
    chk("rst_ifu_rvalid", 32'(out_ifu_rvalid), 32'd0);
    chk("rst_lsu_rvalid", 32'(out_lsu_rvalid), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Ties: IFU first after reset, then LSU, then IFU again.
    ifu_araddr = 32'h3000_0000; ifu_arlen = 8'd0;
    lsu_araddr = 32'h8000_0100; lsu_arsize = 3'b010;
    step_req(1, 1, 0, 1, 0, "tie1");
    step_ar(0, 1, 32'h3000_0000, 4'd0, 8'd0, 3'b010, 2'b00, "tie1");
    step_r(32'h0bad_f00d, 4'd0, 2'b00, 1, 0, 1, 1, 0, "tie1");
    step_req(1, 1, 0, 0, 1, "tie2");
    step_ar(1, 0, 32'h8000_0100, 4'd1, 8'd0, 3'b010, 2'b00, "tie2");
    step_r(32'h1111_2222, 4'd1, 2'b00, 1, 1, 1, 0, 0, "tie2");
    step_req(1, 1, 0, 1, 0, "tie3");
    step_ar(0, 0, 32'h3000_0000, 4'd0, 8'd0, 3'b010, 2'b00, "tie3");
    step_r(32'h3333_4444, 4'd0, 2'b00, 1, 0, 1, 1, 0, "tie3");

    // Lock holds off the LSU until released.
    lsu_araddr = 32'h8000_0200; lsu_arsize = 3'b001;
    step_req(0, 1, 1, 0, 0, "lock1");
    step_req(0, 1, 1, 0, 0, "lock2");
    chk("lock2_arvalid", 32'(m_arvalid), 32'd0);
    step_req(0, 1, 0, 0, 1, "unlock");
    step_ar(0, 0, 32'h8000_0200, 4'd1, 8'd0, 3'b001, 2'b00, "unlock");
    step_r(32'h7777_8888, 4'd1, 2'b00, 1, 1, 1, 0, 0, "unlock");

    // Single-beat vector table.
    for (int i = 0; i < 6; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      if (vecs[i].lsu) begin
        lsu_araddr = vecs[i].addr; lsu_arsize = vecs[i].size;
      end else begin
        ifu_araddr = vecs[i].addr; ifu_arlen = 8'd0;
      end
      step_req(!vecs[i].lsu, vecs[i].lsu, 0, !vecs[i].lsu, vecs[i].lsu, nm);
      step_ar(0, 0, vecs[i].addr, vecs[i].lsu ? 4'd1 : 4'd0, 8'd0,
              vecs[i].lsu ? vecs[i].size : 3'b010, 2'b00, nm);
      step_r(vecs[i].rdata, vecs[i].rid, vecs[i].rresp, 1, vecs[i].lsu, 1, 1,
             vecs[i].exp_err, nm);
    end

    // Excess beat: arlen=0 but slave sends two; second one is drained.
    ifu_araddr = 32'h3000_0100; ifu_arlen = 8'd0;
    step_req(1, 0, 0, 1, 0, "xs");
    step_ar(0, 0, 32'h3000_0100, 4'd0, 8'd0, 3'b010, 2'b00, "xs");
    step_r(32'haaaa_0001, 4'd0, 2'b00, 0, 0, 1, 0, 1, "xs_b0");
    step_r(32'haaaa_0002, 4'd0, 2'b00, 1, 0, 0, 1, 0, "xs_b1");
    step_req(0, 0, 0, 0, 0, "xs_idle");
    chk("xs_idle_rready", 32'(m_rready), 32'd0);

    // Two-beat INCR burst.
    ifu_araddr = 32'ha000_0000; ifu_arlen = 8'd1;
    step_req(1, 0, 0, 1, 0, "burst");
    step_ar(0, 0, 32'ha000_0000, 4'd0, 8'd1, 3'b010, 2'b01, "burst");
    step_r(32'h0000_1111, 4'd0, 2'b00, 0, 0, 1, 1, 0, "burst_b0");
    step_r(32'h0000_2222, 4'd0, 2'b00, 1, 0, 1, 1, 0, "burst_b1");

    // Short burst: rlast on the first of two expected beats.
    step_req(1, 0, 0, 1, 0, "short");
    step_ar(0, 0, 32'ha000_0000, 4'd0, 8'd1, 3'b010, 2'b01, "short");
    step_r(32'h0000_3333, 4'd0, 2'b00, 1, 0, 1, 1, 1, "short");
    step_req(0, 0, 0, 0, 0, "short_idle");
    chk("short_idle_rready", 32'(m_rready), 32'd0);

`ifdef YSYX_RD_ARB_TIMEOUT_EN
    // Watchdog: no R beat ever arrives after the AR handshake.
    ifu_araddr = 32'h5000_0000; ifu_arlen = 8'd0;
    step_req(1, 0, 0, 1, 0, "tmo");
    step_ar(0, 0, 32'h5000_0000, 4'd0, 8'd0, 3'b010, 2'b00, "tmo");
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      m_arready = 1'b0; m_rvalid = 1'b0;
      #1;
      chk($sformatf("tmo_wait%0d", k), 32'(out_ifu_rvalid), 32'd0);
    end
    @(negedge clock);
    #1;
    chk("tmo_rvalid", 32'(out_ifu_rvalid), 32'd1);
    chk("tmo_rlast", 32'(out_ifu_rlast), 32'd1);
    chk("tmo_rerr", 32'(out_ifu_rerr), 32'd1);
    chk("tmo_rdata", out_ifu_rdata, 32'd0);
    step_r(32'hbbbb_0001, 4'd0, 2'b00, 1, 0, 0, 1, 0, "tmo_drain");
    step_req(0, 0, 0, 0, 0, "tmo_idle");
    chk("tmo_idle_rready", 32'(m_rready), 32'd0);
`endif

    // Reset in the middle of a burst clears everything asynchronously.
    ifu_araddr = 32'h4000_0000; ifu_arlen = 8'd3;
    step_req(1, 0, 0, 1, 0, "mrst");
    step_ar(0, 0, 32'h4000_0000, 4'd0, 8'd3, 3'b010, 2'b01, "mrst");
    step_r(32'hcccc_0001, 4'd0, 2'b00, 0, 0, 1, 1, 0, "mrst_b0");
    @(negedge clock);
    m_rdata = 32'hcccc_0002;
    reset = 1'b0;
    #1;
    chk("mrst_ifu_rvalid", 32'(out_ifu_rvalid), 32'd0);
    chk("mrst_ifu_rdata", out_ifu_rdata, 32'd0);
    chk("mrst_rready", 32'(m_rready), 32'd0);
    chk("mrst_araddr", m_araddr, 32'd0);
    chk("mrst_arlen", 32'(m_arlen), 32'd0);
    @(negedge clock);
    reset = 1'b1; m_rvalid = 1'b0; m_rlast = 1'b0;
    ifu_araddr = 32'h4000_0040; ifu_arlen = 8'd0;
    step_req(1, 0, 0, 1, 0, "post_rst");
    step_ar(0, 0, 32'h4000_0040, 4'd0, 8'd0, 3'b010, 2'b00, "post_rst");
    step_r(32'hdddd_0001, 4'd0, 2'b00, 1, 0, 1, 1, 0, "post_rst");
    step_req(0, 0, 0, 0, 0, "end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
